cam_alloc: RTL and testbench

Parametrised content-addressable memory with per-entry data payload, multiple registered lookup ports, and self-managed slot allocation using not-recently-used (NRU) replacement. It is the successor to the single-port, caller-indexed CAM. The insert path picks the slot itself and never creates duplicate keys. Intended for TLB and tag-directory use inside the core.

---
 rtl/cam_alloc.sv | 177 +++++++++++++++++
 tb/tb_cam_alloc.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cam_alloc.sv
// cam_alloc: multi-port CAM with per-entry payload and self-managed slot
// allocation. Inserts update in place on a key hit, otherwise they allocate a
// victim slot (first invalid slot, then first slot whose NRU bit is clear).
// Lookup results are registered one cycle after the request.
module cam_alloc #(
    parameter int NUM_ENTRIES      = 8,
    parameter int KEY_WIDTH        = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_LOOKUP_PORTS = 2,
    parameter int INDEX_WIDTH      = $clog2(NUM_ENTRIES)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_LOOKUP_PORTS-1:0]             lookup_en,
    input  logic [NUM_LOOKUP_PORTS*KEY_WIDTH-1:0]   lookup_key,
    output logic [NUM_LOOKUP_PORTS-1:0]             lookup_hit,
    output logic [NUM_LOOKUP_PORTS*INDEX_WIDTH-1:0] lookup_index,
    output logic [NUM_LOOKUP_PORTS*DATA_WIDTH-1:0]  lookup_data,
    input  logic                                    insert_en,
    input  logic [KEY_WIDTH-1:0]                    insert_key,
    input  logic [DATA_WIDTH-1:0]                   insert_data,
    output logic                                    insert_done,
    output logic [INDEX_WIDTH-1:0]                  insert_index,
    input  logic                                    invalidate_en,
    input  logic [KEY_WIDTH-1:0]                    invalidate_key,
    input  logic                                    flush_all
);

    // Table state. Key/data need no reset: they are only observed through valid.
    logic [NUM_ENTRIES-1:0]                 valid_q, valid_d;
    logic [NUM_ENTRIES-1:0]                 nru_q, nru_d;
    logic [NUM_ENTRIES-1:0][KEY_WIDTH-1:0]  key_q;
    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] data_q;

    // Registered outputs.
    logic [NUM_LOOKUP_PORTS-1:0]                  hit_q, hit_d;
    logic [NUM_LOOKUP_PORTS-1:0][INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [NUM_LOOKUP_PORTS-1:0][DATA_WIDTH-1:0]  dat_q, dat_d;
    logic                                         done_q;
    logic [INDEX_WIDTH-1:0]                       iidx_q;

    // Match vectors and allocation results.
    logic [NUM_LOOKUP_PORTS-1:0][NUM_ENTRIES-1:0] lk_match;
    logic [NUM_ENTRIES-1:0] ins_match, inv_match, ins_sel, inv_clr, touched;
    logic [NUM_ENTRIES-1:0] nru_or, nru_upd;
    logic [INDEX_WIDTH-1:0] ins_idx;
    logic                   do_ins, do_inv;

    // Lowest set bit of a slot vector; 0 when the vector is empty.
    function automatic logic [INDEX_WIDTH-1:0] lowest(input logic [NUM_ENTRIES-1:0] v);
        lowest = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (v[i]) lowest = INDEX_WIDTH'(i);
        end
    endfunction

    // Key comparisons against start-of-cycle table state for every requester.
    always_comb begin
        ins_match = '0;
        inv_match = '0;
        lk_match  = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            ins_match[e] = valid_q[e] && (key_q[e] == insert_key);
            inv_match[e] = valid_q[e] && (key_q[e] == invalidate_key);
            for (int p = 0; p < NUM_LOOKUP_PORTS; p++) begin
                lk_match[p][e] = lookup_en[p] && valid_q[e] &&
                                 (key_q[e] == lookup_key[p*KEY_WIDTH +: KEY_WIDTH]);
            end
        end
    end

    // Lookup result mux: at most one slot matches, so an AND-OR mux suffices
    // and naturally yields zeros on a miss.
    always_comb begin
        hit_d = '0;
        idx_d = '0;
        dat_d = '0;
        for (int p = 0; p < NUM_LOOKUP_PORTS; p++) begin
            hit_d[p] = |lk_match[p];
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (lk_match[p][e]) begin
                    idx_d[p] = idx_d[p] | INDEX_WIDTH'(e);
                    dat_d[p] = dat_d[p] | data_q[e];
                end
            end
        end
    end

    // Slot choice for insert (same-key slot, else victim) and next table state.
    always_comb begin
        do_ins = insert_en && !flush_all;
        do_inv = invalidate_en && !flush_all;

        if (|ins_match)      ins_idx = lowest(ins_match);
        else if (~&valid_q)  ins_idx = lowest(~valid_q);
        else                 ins_idx = lowest(~nru_q);

        ins_sel = '0;
        if (do_ins) ins_sel[ins_idx] = 1'b1;

        // The insert result wins when both target the same slot.
        inv_clr = do_inv ? (inv_match & ~ins_sel) : '0;

        touched = ins_sel;
        for (int p = 0; p < NUM_LOOKUP_PORTS; p++) touched = touched | lk_match[p];

        // NRU saturates to only this cycle's touches once every bit would be set.
        nru_or  = nru_q | touched;
        nru_upd = (&nru_or) ? touched : nru_or;

        if (flush_all) begin
            valid_d = '0;
            nru_d   = '0;
        end else begin
            valid_d = (valid_q | ins_sel) & ~inv_clr;
            nru_d   = nru_upd & ~(inv_clr & ~touched);
        end
    end

    // Control state and registered outputs; reset discards in-flight results.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            nru_q   <= '0;
            hit_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            done_q  <= 1'b0;
            iidx_q  <= '0;
        end else begin
            valid_q <= valid_d;
            nru_q   <= nru_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            done_q  <= do_ins;
            if (do_ins) iidx_q <= ins_idx;
        end
    end

    // Key/payload write for the selected slot.
    always_ff @(posedge clk) begin
        if (!reset && do_ins) begin
            key_q[ins_idx]  <= insert_key;
            data_q[ins_idx] <= insert_data;
        end
    end

    assign lookup_hit   = hit_q;
    assign lookup_index = idx_q;
    assign lookup_data  = dat_q;
    assign insert_done  = done_q;
    assign insert_index = iidx_q;

`ifndef SYNTHESIS
    logic dup_found;

    // Two valid slots with equal keys means the allocation logic is broken.
    always_comb begin
        dup_found = 1'b0;
        for (int a = 0; a < NUM_ENTRIES; a++) begin
            for (int b = a + 1; b < NUM_ENTRIES; b++) begin
                if (valid_q[a] && valid_q[b] && key_q[a] == key_q[b]) dup_found = 1'b1;
            end
        end
    end

    // Stop simulation as soon as a duplicate key is present.
    always_ff @(posedge clk) begin
        if (!reset && dup_found) begin
            $error("cam_alloc: duplicate valid keys in table");
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_cam_alloc.sv
// Scoreboard bench for cam_alloc: each driven cycle pushes the hand-computed
// outputs expected after that cycle's edge; a monitor pops and compares them.
module tb_cam_alloc;
    localparam int NE = 8;
    localparam int KW = 32;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     lookup_en;
    logic [NP*KW-1:0]  lookup_key;
    logic [NP-1:0]     lookup_hit;
    logic [NP*IW-1:0]  lookup_index;
    logic [NP*DW-1:0]  lookup_data;
    logic              insert_en;
    logic [KW-1:0]     insert_key;
    logic [DW-1:0]     insert_data;
    logic              insert_done;
    logic [IW-1:0]     insert_index;
    logic              invalidate_en;
    logic [KW-1:0]     invalidate_key;
    logic              flush_all;

    cam_alloc #(
        .NUM_ENTRIES(NE), .KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUM_LOOKUP_PORTS(NP)
    ) dut (
        .clk(clk), .reset(reset),
        .lookup_en(lookup_en), .lookup_key(lookup_key),
        .lookup_hit(lookup_hit), .lookup_index(lookup_index), .lookup_data(lookup_data),
        .insert_en(insert_en), .insert_key(insert_key), .insert_data(insert_data),
        .insert_done(insert_done), .insert_index(insert_index),
        .invalidate_en(invalidate_en), .invalidate_key(invalidate_key),
        .flush_all(flush_all)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [NP-1:0] hit;
        logic [IW-1:0] idx0, idx1;
        logic [DW-1:0] d0, d1;
        logic          done;
        logic [IW-1:0] iidx;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    function automatic exp_t ex(input logic [1:0] h, input int i0, input logic [31:0] d0,
                                input int i1, input logic [31:0] d1,
                                input logic dn, input int ii);
        exp_t e;
        e.id = 0; e.hit = h;
        e.idx0 = IW'(i0); e.idx1 = IW'(i1);
        e.d0 = d0; e.d1 = d1;
        e.done = dn; e.iidx = IW'(ii);
        return e;
    endfunction

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] exv);
        n_chk++;
        if (act !== exv) begin
            n_fail++;
            $display("FAIL step %0d %s: got %0h expected %0h", id, nm, act, exv);
        end
    endtask

    // Monitor: outputs are settled 1 time unit after the edge that produced them.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk(cur.id, "hit0",  64'(lookup_hit[0]),            64'(cur.hit[0]));
            chk(cur.id, "hit1",  64'(lookup_hit[1]),            64'(cur.hit[1]));
            chk(cur.id, "idx0",  64'(lookup_index[0*IW +: IW]), 64'(cur.idx0));
            chk(cur.id, "idx1",  64'(lookup_index[1*IW +: IW]), 64'(cur.idx1));
            chk(cur.id, "data0", 64'(lookup_data[0*DW +: DW]),  64'(cur.d0));
            chk(cur.id, "data1", 64'(lookup_data[1*DW +: DW]),  64'(cur.d1));
            chk(cur.id, "insert_done",  64'(insert_done),  64'(cur.done));
            chk(cur.id, "insert_index", 64'(insert_index), 64'(cur.iidx));
        end
    end

    // Drive one cycle of stimulus and queue the outputs expected after it.
    task automatic step(input logic rst, input logic fl,
                        input logic ie, input logic [31:0] ik, input logic [31:0] id,
                        input logic ve, input logic [31:0] vk,
                        input logic [1:0] le, input logic [31:0] k0, input logic [31:0] k1,
                        input exp_t e);
        @(negedge clk);
        reset = rst; flush_all = fl;
        insert_en = ie; insert_key = ik; insert_data = id;
        invalidate_en = ve; invalidate_key = vk;
        lookup_en = le; lookup_key = {k1, k0};
        step_id++;
        e.id = step_id;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; flush_all = 1'b0;
        insert_en = 1'b0; insert_key = '0; insert_data = '0;
        invalidate_en = 1'b0; invalidate_key = '0;
        lookup_en = '0; lookup_key = '0;

        // Reset: all outputs zero.
        step(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 0, 0));
        // Lookup on an empty table misses on both ports.
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'h1234, 32'h1234, ex(2'b00, 0, 0, 0, 0, 0, 0));
        // Fill the table; slots allocated in order.
        for (int i = 0; i < 8; i++)
            step(0, 0, 1, 32'hA0 + i, 32'h100 + i, 0, 0, 2'b00, 0, 0,
                 ex(2'b00, 0, 0, 0, 0, 1, i));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA3, 32'hA6,
             ex(2'b11, 3, 32'h103, 6, 32'h106, 0, 7));
        // Touch slots 0 and 1 so slot 2 is the first NRU-clear victim.
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA0, 32'hA1,
             ex(2'b11, 0, 32'h100, 1, 32'h101, 0, 7));
        step(0, 0, 1, 32'hB0, 32'hB00, 0, 0, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 1, 2));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA2, 32'hB0,
             ex(2'b10, 0, 0, 2, 32'hB00, 0, 2));
        // Same-key insert updates in place.
        step(0, 0, 1, 32'hA3, 32'h999, 0, 0, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 1, 3));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA3, 32'hA7,
             ex(2'b11, 3, 32'h999, 7, 32'h107, 0, 3));
        // Insert C0 (victim slot 4), invalidate A5, same-cycle lookup sees old state.
        step(0, 0, 1, 32'hC0, 32'hC00, 1, 32'hA5, 2'b01, 32'hA5, 0,
             ex(2'b01, 5, 32'h105, 0, 0, 1, 4));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA5, 32'hC0,
             ex(2'b10, 0, 0, 4, 32'hC00, 0, 4));
        // Invalidate A7, then confirm it is gone while A6 remains.
        step(0, 0, 0, 0, 0, 1, 32'hA7, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 0, 4));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hA7, 32'hA6,
             ex(2'b10, 0, 0, 6, 32'h106, 0, 4));
        // Port 1 disabled with a valid key present: its outputs stay zero.
        step(0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hA0, 32'hA6,
             ex(2'b01, 0, 32'h100, 0, 0, 0, 4));
        // Flush wins over a same-cycle insert.
        step(0, 1, 1, 32'hD0, 32'hD00, 0, 0, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 0, 4));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hD0, 32'hA0, ex(2'b00, 0, 0, 0, 0, 0, 4));
        step(0, 0, 1, 32'hE0, 32'hE00, 0, 0, 2'b00, 0, 0, ex(2'b00, 0, 0, 0, 0, 1, 0));
        step(0, 0, 0, 0, 0, 0, 0, 2'b11, 32'hE0, 32'hC0,
             ex(2'b01, 0, 32'hE00, 0, 0, 0, 0));
        // Mid-stream reset discards the in-flight lookup and empties the table.
        step(1, 0, 0, 0, 0, 0, 0, 2'b01, 32'hE0, 0, ex(2'b00, 0, 0, 0, 0, 0, 0));
        step(0, 0, 0, 0, 0, 0, 0, 2'b01, 32'hE0, 0, ex(2'b00, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        reset = 1'b0; flush_all = 1'b0; insert_en = 1'b0;
        invalidate_en = 1'b0; lookup_en = '0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #3;
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d expected results never checked, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
